// File: rtl/ttt_pkg.sv
// Shared types, codes and board helpers for the tic-tac-toe turn controller.
package ttt_pkg;

    localparam int unsigned NUM_CELLS = 9;
    localparam int unsigned BOARD_W   = 18;

    localparam logic [1:0] CELL_EMPTY  = 2'd0;
    localparam logic [1:0] CELL_PLAYER = 2'd1;
    localparam logic [1:0] CELL_AI     = 2'd2;

    localparam logic [1:0] RES_NONE   = 2'd0;
    localparam logic [1:0] RES_PLAYER = 2'd1;
    localparam logic [1:0] RES_AI     = 2'd2;
    localparam logic [1:0] RES_DRAW   = 2'd3;

    // Returned by lowest_empty when the board is full.
    localparam logic [3:0] NO_CELL = 4'hf;

    typedef enum logic [2:0] {
        StWaitP,
        StEvalP,
        StAiReq,
        StEvalA,
        StOver
    } ctrl_state_t;

    function automatic logic [1:0] cell_at(input logic [BOARD_W-1:0] board,
                                           input logic [3:0] pos);
        logic [1:0] code;
        code = CELL_EMPTY;
        for (int i = 0; i < int'(NUM_CELLS); i++) begin
            if (pos == 4'(i)) code = board[2*i +: 2];
        end
        return code;
    endfunction

    function automatic logic [BOARD_W-1:0] set_cell(input logic [BOARD_W-1:0] board,
                                                    input logic [3:0] pos,
                                                    input logic [1:0] code);
        logic [BOARD_W-1:0] nb;
        nb = board;
        for (int i = 0; i < int'(NUM_CELLS); i++) begin
            if (pos == 4'(i)) nb[2*i +: 2] = code;
        end
        return nb;
    endfunction

    function automatic logic [3:0] lowest_empty(input logic [BOARD_W-1:0] board);
        logic [3:0] idx;
        idx = NO_CELL;
        for (int i = int'(NUM_CELLS) - 1; i >= 0; i--) begin
            if (board[2*i +: 2] == CELL_EMPTY) idx = 4'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/ttt_board_eval.sv
// Combinational win/draw evaluation of an 18-bit tic-tac-toe board.
module ttt_board_eval
    import ttt_pkg::*;
(
    input  logic [BOARD_W-1:0] board,
    output logic [1:0]         result
);

    localparam int unsigned LINES [8][3] = '{
        '{0, 1, 2}, '{3, 4, 5}, '{6, 7, 8},
        '{0, 3, 6}, '{1, 4, 7}, '{2, 5, 8},
        '{0, 4, 8}, '{2, 4, 6}
    };

    logic       player_win;
    logic       ai_win;
    logic       any_empty;
    logic [1:0] c0, c1, c2;

    always_comb begin
        player_win = 1'b0;
        ai_win     = 1'b0;
        any_empty  = 1'b0;
        c0         = CELL_EMPTY;
        c1         = CELL_EMPTY;
        c2         = CELL_EMPTY;
        for (int l = 0; l < 8; l++) begin
            c0 = cell_at(board, 4'(LINES[l][0]));
            c1 = cell_at(board, 4'(LINES[l][1]));
            c2 = cell_at(board, 4'(LINES[l][2]));
            if (c0 == c1 && c1 == c2) begin
                if (c0 == CELL_PLAYER) player_win = 1'b1;
                if (c0 == CELL_AI)     ai_win     = 1'b1;
            end
        end
        for (int i = 0; i < int'(NUM_CELLS); i++) begin
            if (board[2*i +: 2] == CELL_EMPTY) any_empty = 1'b1;
        end
    end

    // Player win takes precedence; a legal game can never yield both.
    always_comb begin
        if (player_win)      result = RES_PLAYER;
        else if (ai_win)     result = RES_AI;
        else if (!any_empty) result = RES_DRAW;
        else                 result = RES_NONE;
    end

endmodule

// File: rtl/ttt_game_ctrl.sv
// Tic-tac-toe turn sequencer: board owner, AI req/ack handshake, win/draw tracking.
// Define TTT_AI_TIMEOUT_EN to enable the AI engine watchdog (TIMEOUT_CYCLES).
module ttt_game_ctrl
    import ttt_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               move_stb,
    input  logic [3:0]         move_pos,
    output logic               ai_req,
    output logic [BOARD_W-1:0] ai_board,
    input  logic               ai_ack,
    input  logic [3:0]         ai_pos,
    output logic [BOARD_W-1:0] board,
    output logic [1:0]         result,
    output logic [2:0]         led,
    output logic               busy,
    output logic               illegal
);

    ctrl_state_t        state_q, state_d;
    logic [BOARD_W-1:0] board_q, board_d;
    logic [BOARD_W-1:0] ai_board_q, ai_board_d;
    logic [1:0]         result_q, result_d;
    logic [2:0]         led_q, led_d;
    logic               ai_req_q, ai_req_d;
    logic               illegal_q, illegal_d;
    logic [1:0]         eval_res;
    logic [3:0]         ai_cell;
    logic [3:0]         sel_cell;
    logic               timeout;
    logic               ai_done;
    logic               move_ok;

    // Evaluator always sees the live board; only EVAL_P/EVAL_A consume it.
    ttt_board_eval u_eval (
        .board  (board_q),
        .result (eval_res)
    );

`ifdef TTT_AI_TIMEOUT_EN
    localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CntW-1:0] cnt_q, cnt_d;

    assign timeout = (state_q == StAiReq) && (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        cnt_d = '0;
        if (state_q == StAiReq) cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
`else
    logic unused_timeout_cfg;

    assign timeout            = 1'b0;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

    assign move_ok  = (move_pos <= 4'd8) && (cell_at(board_q, move_pos) == CELL_EMPTY);
    assign ai_cell  = ((ai_pos <= 4'd8) && (cell_at(board_q, ai_pos) == CELL_EMPTY)) ?
                      ai_pos : lowest_empty(board_q);
    assign ai_done  = ai_ack | timeout;
    assign sel_cell = ai_ack ? ai_cell : lowest_empty(board_q);

    always_comb begin
        state_d    = state_q;
        board_d    = board_q;
        ai_board_d = ai_board_q;
        result_d   = result_q;
        led_d      = led_q;
        ai_req_d   = ai_req_q;
        illegal_d  = 1'b0;
        unique case (state_q)
            StWaitP: begin
                if (move_stb) begin
                    if (move_ok) begin
                        board_d = set_cell(board_q, move_pos, CELL_PLAYER);
                        state_d = StEvalP;
                    end else begin
                        illegal_d = 1'b1;
                    end
                end
            end
            StEvalP, StEvalA: begin
                result_d = eval_res;
                unique case (eval_res)
                    RES_PLAYER: led_d[0] = 1'b1;
                    RES_AI:     led_d[1] = 1'b1;
                    RES_DRAW:   led_d[2] = 1'b1;
                    default:    ;
                endcase
                if (eval_res != RES_NONE) begin
                    state_d = StOver;
                end else if (state_q == StEvalP) begin
                    state_d    = StAiReq;
                    ai_req_d   = 1'b1;
                    ai_board_d = board_q;
                end else begin
                    state_d = StWaitP;
                end
            end
            StAiReq: begin
                if (ai_done) begin
                    ai_req_d = 1'b0;
                    board_d  = set_cell(board_q, sel_cell, CELL_AI);
                    state_d  = StEvalA;
                end
            end
            StOver: ;
            default: state_d = StWaitP;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StWaitP;
            board_q    <= '0;
            ai_board_q <= '0;
            result_q   <= RES_NONE;
            led_q      <= '0;
            ai_req_q   <= 1'b0;
            illegal_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            board_q    <= board_d;
            ai_board_q <= ai_board_d;
            result_q   <= result_d;
            led_q      <= led_d;
            ai_req_q   <= ai_req_d;
            illegal_q  <= illegal_d;
        end
    end

    assign board    = board_q;
    assign ai_board = ai_board_q;
    assign result   = result_q;
    assign led      = led_q;
    assign ai_req   = ai_req_q;
    assign illegal  = illegal_q;
    assign busy     = (state_q != StWaitP);

endmodule

// File: tb/tb_ttt_game_ctrl.sv
// Self-checking bench for ttt_game_ctrl: directed scenarios plus randomized games.
module tb_ttt_game_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        move_stb = 1'b0;
    logic [3:0]  move_pos = '0;
    logic        ai_req;
    logic [17:0] ai_board;
    logic        ai_ack = 1'b0;
    logic [3:0]  ai_pos = '0;
    logic [17:0] board;
    logic [1:0]  result;
    logic [2:0]  led;
    logic        busy;
    logic        illegal;

    int vectors = 0;
    int miscompares = 0;

    int         mc[9];
    int         mres;
    logic [2:0] mled;

    ttt_game_ctrl #(.TIMEOUT_CYCLES(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .move_stb (move_stb),
        .move_pos (move_pos),
        .ai_req   (ai_req),
        .ai_board (ai_board),
        .ai_ack   (ai_ack),
        .ai_pos   (ai_pos),
        .board    (board),
        .result   (result),
        .led      (led),
        .busy     (busy),
        .illegal  (illegal)
    );

    always #5 clk = ~clk;

    function automatic logic [17:0] m_board();
        logic [17:0] b;
        b = '0;
        for (int i = 0; i < 9; i++) b[2*i +: 2] = 2'(mc[i]);
        return b;
    endfunction

    function automatic int owner3(input int a, input int b, input int c);
        if (mc[a] != 0 && mc[a] == mc[b] && mc[b] == mc[c]) return mc[a];
        return 0;
    endfunction

    function automatic int m_eval();
        int owners[$];
        for (int r = 0; r < 3; r++) begin
            owners.push_back(owner3(3*r, 3*r + 1, 3*r + 2));
            owners.push_back(owner3(r, r + 3, r + 6));
        end
        owners.push_back(owner3(0, 4, 8));
        owners.push_back(owner3(2, 4, 6));
        foreach (owners[k]) if (owners[k] == 1) return 1;
        foreach (owners[k]) if (owners[k] == 2) return 2;
        for (int i = 0; i < 9; i++) if (mc[i] == 0) return 0;
        return 3;
    endfunction

    function automatic int m_lowest();
        for (int i = 0; i < 9; i++) if (mc[i] == 0) return i;
        return -1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        move_stb = 1'b0;
        ai_ack = 1'b0;
        step();
        rst = 1'b0;
        for (int i = 0; i < 9; i++) mc[i] = 0;
        mres = 0;
        mled = '0;
    endtask

    task automatic player_move(input int p);
        move_stb = 1'b1;
        move_pos = 4'(p);
        step();
        move_stb = 1'b0;
    endtask

    task automatic ai_answer(input int q);
        ai_ack = 1'b1;
        ai_pos = 4'(q);
        step();
        ai_ack = 1'b0;
    endtask

    task automatic test_reset();
        move_stb = 1'b1;
        move_pos = 4'd3;
        rst = 1'b1;
        step();
        rst = 1'b0;
        move_stb = 1'b0;
        for (int i = 0; i < 9; i++) mc[i] = 0;
        mres = 0;
        mled = '0;
        vectors += 7;
        if (board !== 18'h0) begin
            miscompares++; $display("FAIL reset_board got %h exp 0", board);
        end
        if (result !== 2'd0) begin
            miscompares++; $display("FAIL reset_result got %0d exp 0", result);
        end
        if (led !== 3'b000) begin
            miscompares++; $display("FAIL reset_led got %b exp 000", led);
        end
        if (ai_req !== 1'b0) begin
            miscompares++; $display("FAIL reset_ai_req got %b exp 0", ai_req);
        end
        if (ai_board !== 18'h0) begin
            miscompares++; $display("FAIL reset_ai_board got %h exp 0", ai_board);
        end
        if (illegal !== 1'b0) begin
            miscompares++; $display("FAIL reset_illegal got %b exp 0", illegal);
        end
        if (busy !== 1'b0) begin
            miscompares++; $display("FAIL reset_busy got %b exp 0", busy);
        end
    endtask

    task automatic test_basic_turn();
        do_reset();
        player_move(4);
        vectors += 3;
        if (board !== 18'h00100) begin
            miscompares++; $display("FAIL basic_board_n1 got %h exp 00100", board);
        end
        if (ai_req !== 1'b0) begin
            miscompares++; $display("FAIL basic_req_n1 got %b exp 0", ai_req);
        end
        if (busy !== 1'b1) begin
            miscompares++; $display("FAIL basic_busy_n1 got %b exp 1", busy);
        end
        step();
        vectors += 2;
        if (ai_req !== 1'b1) begin
            miscompares++; $display("FAIL basic_req_n2 got %b exp 1", ai_req);
        end
        if (ai_board !== 18'h00100) begin
            miscompares++; $display("FAIL basic_ai_board got %h exp 00100", ai_board);
        end
        ai_answer(0);
        vectors += 2;
        if (board !== 18'h00102) begin
            miscompares++; $display("FAIL basic_board_m1 got %h exp 00102", board);
        end
        if (ai_req !== 1'b0) begin
            miscompares++; $display("FAIL basic_req_m1 got %b exp 0", ai_req);
        end
        step();
        vectors += 2;
        if (busy !== 1'b0) begin
            miscompares++; $display("FAIL basic_busy_m2 got %b exp 0", busy);
        end
        if (result !== 2'd0) begin
            miscompares++; $display("FAIL basic_result_m2 got %0d exp 0", result);
        end
    endtask

    // Runs on the board left by test_basic_turn: P at 4, A at 0.
    task automatic test_illegal();
        int bad[3] = '{4, 9, 0};
        foreach (bad[k]) begin
            player_move(bad[k]);
            vectors += 3;
            if (illegal !== 1'b1) begin
                miscompares++; $display("FAIL illegal_pulse pos %0d got %b exp 1", bad[k], illegal);
            end
            if (board !== 18'h00102) begin
                miscompares++; $display("FAIL illegal_board pos %0d got %h exp 00102", bad[k], board);
            end
            if (busy !== 1'b0) begin
                miscompares++; $display("FAIL illegal_busy pos %0d got %b exp 0", bad[k], busy);
            end
            step();
            vectors++;
            if (illegal !== 1'b0) begin
                miscompares++; $display("FAIL illegal_width pos %0d got %b exp 0", bad[k], illegal);
            end
        end
    endtask

    task automatic test_fallback();
        do_reset();
        player_move(4);
        step();
        ai_answer(4);
        vectors++;
        if (board !== 18'h00102) begin
            miscompares++; $display("FAIL fallback_board got %h exp 00102", board);
        end
    endtask

    task automatic test_player_win();
        do_reset();
        player_move(0); step(); ai_answer(3); step();
        player_move(1); step(); ai_answer(4); step();
        player_move(2);
        vectors++;
        if (board !== 18'h00295) begin
            miscompares++; $display("FAIL win_board got %h exp 00295", board);
        end
        step();
        vectors += 3;
        if (result !== 2'd1) begin
            miscompares++; $display("FAIL win_result got %0d exp 1", result);
        end
        if (led !== 3'b001) begin
            miscompares++; $display("FAIL win_led got %b exp 001", led);
        end
        if (busy !== 1'b1) begin
            miscompares++; $display("FAIL win_busy got %b exp 1", busy);
        end
        for (int c = 0; c < 3; c++) begin
            step();
            vectors++;
            if (ai_req !== 1'b0) begin
                miscompares++; $display("FAIL win_no_req cyc %0d got %b exp 0", c, ai_req);
            end
        end
        player_move(5);
        vectors += 2;
        if (illegal !== 1'b0) begin
            miscompares++; $display("FAIL over_illegal got %b exp 0", illegal);
        end
        if (board !== 18'h00295) begin
            miscompares++; $display("FAIL over_move_board got %h exp 00295", board);
        end
        ai_answer(6);
        step();
        vectors += 2;
        if (board !== 18'h00295) begin
            miscompares++; $display("FAIL over_ack_board got %h exp 00295", board);
        end
        if (result !== 2'd1) begin
            miscompares++; $display("FAIL over_result got %0d exp 1", result);
        end
    endtask

    task automatic test_draw();
        int pm[4] = '{0, 8, 7, 2};
        int am[4] = '{4, 1, 6, 5};
        do_reset();
        for (int k = 0; k < 4; k++) begin
            player_move(pm[k]); step(); ai_answer(am[k]); step();
        end
        player_move(3);
        step();
        vectors += 5;
        if (board !== 18'h16A59) begin
            miscompares++; $display("FAIL draw_board got %h exp 16a59", board);
        end
        if (result !== 2'd3) begin
            miscompares++; $display("FAIL draw_result got %0d exp 3", result);
        end
        if (led !== 3'b100) begin
            miscompares++; $display("FAIL draw_led got %b exp 100", led);
        end
        if (busy !== 1'b1) begin
            miscompares++; $display("FAIL draw_busy got %b exp 1", busy);
        end
        if (ai_req !== 1'b0) begin
            miscompares++; $display("FAIL draw_req got %b exp 0", ai_req);
        end
    endtask

    task automatic test_random_games(input int games);
        int p;
        int q;
        int d;
        for (int g = 0; g < games; g++) begin
            do_reset();
            for (int t = 0; t < 40 && mres == 0; t++) begin
                if ($urandom_range(0, 3) == 0) begin
                    ai_answer($urandom_range(0, 15));
                    vectors++;
                    if (board !== m_board()) begin
                        miscompares++;
                        $display("FAIL rnd_stray_ack got %h exp %h", board, m_board());
                    end
                end
                vectors++;
                if (busy !== 1'b0) begin
                    miscompares++; $display("FAIL rnd_ready got %b exp 0", busy);
                end
                p = $urandom_range(0, 10);
                player_move(p);
                if (p > 8 || mc[p] != 0) begin
                    vectors += 2;
                    if (illegal !== 1'b1) begin
                        miscompares++; $display("FAIL rnd_illegal pos %0d got %b exp 1", p, illegal);
                    end
                    if (board !== m_board()) begin
                        miscompares++;
                        $display("FAIL rnd_ill_board got %h exp %h", board, m_board());
                    end
                    step();
                    continue;
                end
                mc[p] = 1;
                vectors += 2;
                if (board !== m_board()) begin
                    miscompares++; $display("FAIL rnd_p_board got %h exp %h", board, m_board());
                end
                if (illegal !== 1'b0) begin
                    miscompares++; $display("FAIL rnd_p_illegal got %b exp 0", illegal);
                end
                step();
                mres = m_eval();
                if (mres != 0) mled[mres-1] = 1'b1;
                vectors += 3;
                if (result !== 2'(mres)) begin
                    miscompares++; $display("FAIL rnd_p_result got %0d exp %0d", result, mres);
                end
                if (led !== mled) begin
                    miscompares++; $display("FAIL rnd_p_led got %b exp %b", led, mled);
                end
                if (ai_req !== (mres == 0)) begin
                    miscompares++; $display("FAIL rnd_req got %b exp %b", ai_req, mres == 0);
                end
                if (mres != 0) break;
                vectors++;
                if (ai_board !== m_board()) begin
                    miscompares++;
                    $display("FAIL rnd_ai_board got %h exp %h", ai_board, m_board());
                end
                d = $urandom_range(0, 3);
                for (int w = 0; w < d; w++) begin
                    player_move($urandom_range(0, 15));
                    vectors += 2;
                    if (ai_req !== 1'b1) begin
                        miscompares++; $display("FAIL rnd_req_hold got %b exp 1", ai_req);
                    end
                    if (board !== m_board()) begin
                        miscompares++;
                        $display("FAIL rnd_busy_move got %h exp %h", board, m_board());
                    end
                end
                q = $urandom_range(0, 15);
                ai_answer(q);
                if (q <= 8 && mc[q] == 0) mc[q] = 2;
                else mc[m_lowest()] = 2;
                vectors += 2;
                if (board !== m_board()) begin
                    miscompares++;
                    $display("FAIL rnd_a_board pos %0d got %h exp %h", q, board, m_board());
                end
                if (ai_req !== 1'b0) begin
                    miscompares++; $display("FAIL rnd_req_drop got %b exp 0", ai_req);
                end
                step();
                mres = m_eval();
                if (mres != 0) mled[mres-1] = 1'b1;
                vectors += 3;
                if (result !== 2'(mres)) begin
                    miscompares++; $display("FAIL rnd_a_result got %0d exp %0d", result, mres);
                end
                if (led !== mled) begin
                    miscompares++; $display("FAIL rnd_a_led got %b exp %b", led, mled);
                end
                if (busy !== (mres != 0)) begin
                    miscompares++; $display("FAIL rnd_a_busy got %b exp %b", busy, mres != 0);
                end
            end
            if (mres != 0) begin
                player_move($urandom_range(0, 8));
                vectors += 2;
                if (illegal !== 1'b0) begin
                    miscompares++; $display("FAIL rnd_over_illegal got %b exp 0", illegal);
                end
                if (board !== m_board()) begin
                    miscompares++;
                    $display("FAIL rnd_over_board got %h exp %h", board, m_board());
                end
            end
        end
    endtask

    task automatic test_reset_mid_handshake();
        do_reset();
        player_move(2);
        step();
        vectors++;
        if (ai_req !== 1'b1) begin
            miscompares++; $display("FAIL rstmid_req_before got %b exp 1", ai_req);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        vectors += 3;
        if (ai_req !== 1'b0) begin
            miscompares++; $display("FAIL rstmid_req got %b exp 0", ai_req);
        end
        if (board !== 18'h0) begin
            miscompares++; $display("FAIL rstmid_board got %h exp 0", board);
        end
        if (busy !== 1'b0) begin
            miscompares++; $display("FAIL rstmid_busy got %b exp 0", busy);
        end
    endtask

`ifdef TTT_AI_TIMEOUT_EN
    task automatic test_timeout();
        int cyc;
        do_reset();
        player_move(4);
        step();
        cyc = 0;
        while (ai_req === 1'b1 && cyc < 100) begin
            step();
            cyc++;
        end
        vectors += 2;
        if (cyc != 16) begin
            miscompares++; $display("FAIL timeout_cycles got %0d exp 16", cyc);
        end
        if (board !== 18'h00102) begin
            miscompares++; $display("FAIL timeout_board got %h exp 00102", board);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic_turn();
        test_illegal();
        test_fallback();
        test_player_win();
        test_draw();
        test_random_games(30);
        test_reset_mid_handshake();
`ifdef TTT_AI_TIMEOUT_EN
        test_timeout();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
